phase_sampler: RTL
==================

Name: phase_sampler

Overview:
- Run controller and spin readout stage directly downstream of the coupled-oscillator matrix.
- Drives the matrix's ising_rstn to start a run, waits a programmable settle time, then samples every oscillator output (outputs_ver) against oscillator 0 over a fixed window.
- Majority-votes each phase into a spin bit and exposes control, status and spins on the same 32-bit AXI-lite-style register bus used for weight writes.

Parameters:
- N, 3: number of spins/oscillators (1..256).
- SAMPLE_CYCLES, 64: sampling window length in clk cycles (>=1).
- DEFAULT_SETTLE, 1024: settle-register reset value.

Ports:
- clk  in  1  system clock.
- axi_rst  in  1  reset, synchronous, active-high.
- osc_in  in  N  outputs_ver from the matrix; asynchronous to clk.
- ising_rstn  out  1  oscillator-array enable (active-low reset) to the matrix.
- wready  in  1  write strobe.
- wr_addr  in  32  write address.
- wdata  in  32  write data.
- rready  in  1  read strobe.
- rd_addr  in  32  read address.
- rdata  out  32  read data.
- rvalid  out  1  rdata valid.
- done_irq  out  1  one-cycle pulse when a run completes.

Behaviour:
- One clock; reset is synchronous and active-high (axi_rst sampled on clk rising edge).
- Reset values:
  - state=IDLE, ising_rstn=0, rdata=0, rvalid=0, done_irq=0.
  - settle register=DEFAULT_SETTLE, spin register=0, done flag=0, all counters=0.
- Input capture:
  - Each osc_in bit passes through a 2-flop synchronizer (2-cycle latency).
  - mismatch[i] = sync[i] XOR sync[0].
- Registers (addresses defined as `PS_* macros in defines.vh):
  - PS_CTRL_ADDR write: wdata[0] = start; wdata[1] = abort.
  - PS_SETTLE_ADDR: read/write, 32-bit.
  - PS_STATUS_ADDR: read-only. bit0 = busy (SETTLE or SAMPLE); bit1 = done; bits[3:2] = state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3).
  - PS_SPIN_ADDR_BASE + 4k: read-only, spins 32k..32k+31, bit j = spin 32k+j. Bits beyond N read 0.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Reads:
  - rready with rd_addr captured at edge T -> rdata valid and rvalid=1 for exactly the cycle after T.
  - rdata holds its value until the next read.
- FSM:
  - IDLE: start -> SETTLE next cycle. Load settle counter with max(settle,1); clear all mismatch counters; done=0; ising_rstn=1 from that cycle.
  - SETTLE: decrement each cycle; on reaching 1 -> SAMPLE. SETTLE therefore lasts max(settle,1) cycles.
  - SAMPLE: each cycle, cnt[i] += mismatch[i]. Counter width is clog2(SAMPLE_CYCLES+1) and cannot overflow. After exactly SAMPLE_CYCLES cycles -> DONE.
  - DONE entry, same edge:
    - spin[i] = (cnt[i] > SAMPLE_CYCLES/2), strict, integer division.
    - spin[0] is always 0.
    - done=1; done_irq pulses for 1 cycle; ising_rstn=0.
  - DONE: start behaves as in IDLE (spins retained until the new DONE).
- Abort in any state -> IDLE next cycle, ising_rstn=0, done=0. Spins and counts are retained. Abort takes priority over start in the same write.
- Start while in SETTLE/SAMPLE is ignored.
- A write to PS_SETTLE_ADDR during SETTLE does not affect the running count.
- Simultaneous write and read in one cycle are both serviced. A read of STATUS returns the pre-edge state.
- axi_rst mid-run: everything returns to reset values on the next edge, including ising_rstn=0.

Optional Feature:
- PHASE_SAMPLER_RAW_COUNTS_EN defined:
  - PS_COUNT_ADDR_BASE + 4i returns the zero-extended cnt[i] of the last completed run, latched at DONE entry.
- Undefined:
  - Those addresses are unmapped and read 0.
  - Count snapshot storage is not synthesized.

Decomposition:
- defines.vh holds:
  - PS_CTRL_ADDR, PS_SETTLE_ADDR, PS_STATUS_ADDR, PS_SPIN_ADDR_BASE, PS_COUNT_ADDR_BASE, all non-overlapping with WEIGHT_ADDR_BASE.
  - State encodings.
  - CTRL bit positions.
- Sub-module sync_2ff (1-bit, no reset), instantiated N times.

Test Plan:
- Reset, then read STATUS -> rdata=0x0, rvalid one cycle after rready; ising_rstn=0; SPIN word 0 = 0.
- N=4, SAMPLE_CYCLES=16, settle=5: start at edge T -> ising_rstn rises at T+1; SAMPLE begins T+6; done_irq at T+22; STATUS=0xE (done=1, state DONE) afterward.
- Drive osc[0] and osc[2] in-phase, osc[1] and osc[3] inverted, as 4-cycle square waves -> SPIN word 0 = 0xA. With PHASE_SAMPLER_RAW_COUNTS_EN: counts 0,16,0,16.
- osc[1] mismatches exactly 8 of 16 cycles -> spin1=0. Mismatches 9 of 16 -> spin1=1.
- Abort written mid-SAMPLE -> IDLE next cycle, ising_rstn=0, no done_irq, previous spins still readable. Start during SETTLE -> no restart, timing unchanged.
- settle=0 -> SETTLE lasts 1 cycle. axi_rst asserted during SAMPLE -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/phase_sampler_pkg.sv
// phase_sampler shared definitions: register map macros, state encoding,
// CTRL bit positions and small helpers.
// Optional feature macro: PHASE_SAMPLER_RAW_COUNTS_EN (raw count readback).
// The PS_* register map sits in its own 64 KiB page so it cannot collide
// with the weight-write window of the oscillator matrix.
`ifndef PS_CTRL_ADDR
`define PS_CTRL_ADDR        32'h0001_0000
`endif
`ifndef PS_SETTLE_ADDR
`define PS_SETTLE_ADDR      32'h0001_0004
`endif
`ifndef PS_STATUS_ADDR
`define PS_STATUS_ADDR      32'h0001_0008
`endif
`ifndef PS_SPIN_ADDR_BASE
`define PS_SPIN_ADDR_BASE   32'h0001_0100
`endif
`ifndef PS_COUNT_ADDR_BASE
`define PS_COUNT_ADDR_BASE  32'h0001_0200
`endif

package phase_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } ps_state_t;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // A programmed settle of zero still spends one cycle in SETTLE.
  function automatic logic [31:0] settle_load(input logic [31:0] settle);
    return (settle == 32'd0) ? 32'd1 : settle;
  endfunction

endpackage

// File: rtl/phase_sampler_sync_2ff.sv
// Two-flop synchronizer for one asynchronous oscillator output. No reset:
// the chain flushes within two clocks and its contents are never trusted
// before the sampling window opens.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/phase_sampler.sv
// phase_sampler: run controller and spin readout for the oscillator matrix.
// Releases ising_rstn, waits the settle time, counts per-oscillator phase
// mismatches against oscillator 0 over SAMPLE_CYCLES, and majority-votes
// each count into a spin bit. Optional macro PHASE_SAMPLER_RAW_COUNTS_EN
// adds a snapshot of the raw counts readable at PS_COUNT_ADDR_BASE + 4i.
module phase_sampler
  import phase_sampler_pkg::*;
#(
  parameter int          N              = 3,
  parameter int          SAMPLE_CYCLES  = 64,
  parameter logic [31:0] DEFAULT_SETTLE = 32'd1024
) (
  input  logic          clk,
  input  logic          axi_rst,
  input  logic [N-1:0]  osc_in,
  output logic          ising_rstn,
  input  logic          wready,
  input  logic [31:0]   wr_addr,
  input  logic [31:0]   wdata,
  input  logic          rready,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rdata,
  output logic          rvalid,
  output logic          done_irq
);

  localparam int            CW          = $clog2(SAMPLE_CYCLES + 1);
  localparam int            NW          = (N + 31) / 32;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] HALF        = CW'(SAMPLE_CYCLES / 2);

  logic [N-1:0]      sync;
  logic [N-1:0]      mismatch;
  ps_state_t         state;
  logic [31:0]       settle_reg;
  logic [31:0]       settle_cnt;
  logic [CW-1:0]     sample_cnt;
  logic [CW-1:0]     cnt      [N];
  logic [CW-1:0]     cnt_next [N];
  logic [N-1:0]      spin;
  logic [N-1:0]      spin_next;
  logic              done_flag;
  logic              ctrl_wr;
  logic              start;
  logic              abort;
  logic              done_entry;
  logic              busy;
  logic [31:0]       status_word;
  logic [32*NW-1:0]  spin_pad;
  logic [31:0]       spin_off;
  logic [31:0]       rd_word;

  for (genvar g = 0; g < N; g++) begin : g_sync
    sync_2ff u_sync (
      .clk (clk),
      .d   (osc_in[g]),
      .q   (sync[g])
    );
  end

  assign mismatch    = sync ^ {N{sync[0]}};
  assign ctrl_wr     = wready && (wr_addr == `PS_CTRL_ADDR);
  assign start       = ctrl_wr && wdata[CTRL_START_BIT];
  assign abort       = ctrl_wr && wdata[CTRL_ABORT_BIT];
  assign done_entry  = (state == ST_SAMPLE) && !abort && (sample_cnt == LAST_SAMPLE);
  assign busy        = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign status_word = {28'd0, state, done_flag, busy};
  assign spin_pad    = (32*NW)'(spin);
  assign spin_off    = rd_addr - `PS_SPIN_ADDR_BASE;

  // Next mismatch counts and the majority vote taken on the final sample;
  // oscillator 0 is the phase reference, so its spin is forced to 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_next[i]  = cnt[i] + CW'(mismatch[i]);
      spin_next[i] = (cnt_next[i] > HALF);
    end
    spin_next[0] = 1'b0;
  end

  // Settle register: software-programmable, read back verbatim.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      settle_reg <= DEFAULT_SETTLE;
    end else if (wready && (wr_addr == `PS_SETTLE_ADDR)) begin
      settle_reg <= wdata;
    end
  end

  // Run FSM: abort wins over everything, start is honoured only when idle/done.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      state      <= ST_IDLE;
      ising_rstn <= 1'b0;
      done_irq   <= 1'b0;
      done_flag  <= 1'b0;
      settle_cnt <= 32'd0;
      sample_cnt <= '0;
      spin       <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      done_irq <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        ising_rstn <= 1'b0;
        done_flag  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state      <= ST_SETTLE;
              settle_cnt <= settle_load(settle_reg);
              sample_cnt <= '0;
              done_flag  <= 1'b0;
              ising_rstn <= 1'b1;
              for (int i = 0; i < N; i++) cnt[i] <= '0;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt <= 32'd1) begin
              state <= ST_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - 32'd1;
            end
          end
          ST_SAMPLE: begin
            for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
            sample_cnt <= sample_cnt + CW'(1);
            if (done_entry) begin
              state      <= ST_DONE;
              spin       <= spin_next;
              done_flag  <= 1'b1;
              done_irq   <= 1'b1;
              ising_rstn <= 1'b0;
            end
          end
          default: begin
            state      <= ST_IDLE;
            ising_rstn <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PHASE_SAMPLER_RAW_COUNTS_EN
  logic [CW-1:0] cnt_snap [N];
  logic [31:0]   cnt_off;

  assign cnt_off = rd_addr - `PS_COUNT_ADDR_BASE;

  // Latch the final counts of each completed run for raw readback.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      for (int i = 0; i < N; i++) cnt_snap[i] <= '0;
    end else if (done_entry) begin
      for (int i = 0; i < N; i++) cnt_snap[i] <= cnt_next[i];
    end
  end
`endif

  // Read decode; address ranges are disjoint so later hits cannot clobber earlier ones.
  always_comb begin
    rd_word = 32'd0;
    if (rd_addr == `PS_SETTLE_ADDR) begin
      rd_word = settle_reg;
    end else if (rd_addr == `PS_STATUS_ADDR) begin
      rd_word = status_word;
    end else begin
      for (int k = 0; k < NW; k++) begin
        rd_word = (spin_off == 32'(4*k)) ? spin_pad[32*k +: 32] : rd_word;
      end
`ifdef PHASE_SAMPLER_RAW_COUNTS_EN
      for (int i = 0; i < N; i++) begin
        rd_word = (cnt_off == 32'(4*i)) ? 32'(cnt_snap[i]) : rd_word;
      end
`endif
    end
  end

  // Registered read port: one-cycle rvalid, rdata held until the next read.
  always_ff @(posedge clk) begin
    if (axi_rst) begin
      rdata  <= 32'd0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rready;
      if (rready) begin
        rdata <= rd_word;
      end
    end
  end

endmodule
